// File: rtl/vga_arb_pkg.sv
// Shared encodings for the VGA WISHBONE arbiter: FSM states and one-hot grant codes.
package vga_arb_pkg;

   // The state encoding doubles as the one-hot grant pattern.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_GNT0 = 2'b01,
      ARB_GNT1 = 2'b10
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/vga_arb_wdog.sv
// Per-grant watchdog counter: clear, enable, terminal-count flag.
// tc_o flags the cycle whose enabled count brings the counter to all-ones,
// i.e. the (2^TO_W-1)th counted cycle since the last clear.
module vga_arb_wdog
   import vga_arb_pkg::*;
#(
   parameter int unsigned TO_W = 8
) (
   input  logic clk_i,
   input  logic nrst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [TO_W-1:0] CntMax = '1;
   localparam logic [TO_W-1:0] CntPre = CntMax - TO_W'(1);

   logic [TO_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   // Terminal count for the current counted cycle.
   always_comb begin
      tc_o = en_i & (cnt_q == CntPre);
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_wb_arbiter.sv
// Two-master WISHBONE arbiter for the VGA core (frame fetch m0, secondary fetch m1).
// Cycle-locked grants with one idle cycle between owners and a per-grant watchdog.
// Optional build macro VGA_ARB_RR_EN: round-robin tie break instead of m0 priority.
module vga_wb_arbiter
   import vga_arb_pkg::*;
#(
   parameter int unsigned TO_W = 8
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_cab_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_cab_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        cab_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic [31:0] dat_i,
   output logic [1:0]  gnt_o,
   output logic        tmo_o
);

   arb_state_e state_q, state_d;
   // Set when a master was aborted by the watchdog while still holding cyc.
   logic       blk0_q, blk0_d;
   logic       blk1_q, blk1_d;
`ifdef VGA_ARB_RR_EN
   // 1 = m1 was served last; resets to m1 so m0 wins the first tie.
   logic       last1_q, last1_d;
`endif

   logic req0, req1;
   logic term;
   logic wd_clr, wd_en, wd_tc;
   logic fire;

   // Read data is fanned out to the masters outside this block.
   logic unused_dat;
   assign unused_dat = ^dat_i;

   // Shared bus mux driven from the registered owner.
   always_comb begin
      cyc_o = 1'b0;
      stb_o = 1'b0;
      cab_o = 1'b0;
      we_o  = 1'b0;
      adr_o = '0;
      sel_o = 4'b1111;
      gnt_o = GNT_NONE;
      case (state_q)
         ARB_GNT0: begin
            cyc_o = m0_cyc_i;
            stb_o = m0_stb_i;
            cab_o = m0_cab_i;
            we_o  = m0_we_i;
            adr_o = m0_adr_i;
            sel_o = m0_sel_i;
            gnt_o = GNT_M0;
         end
         ARB_GNT1: begin
            cyc_o = m1_cyc_i;
            stb_o = m1_stb_i;
            cab_o = m1_cab_i;
            we_o  = m1_we_i;
            adr_o = m1_adr_i;
            sel_o = m1_sel_i;
            gnt_o = GNT_M1;
         end
         default: ;
      endcase
   end

   // Watchdog control; a slave termination in the terminal cycle beats the timeout.
   always_comb begin
      term   = ack_i | err_i;
      wd_en  = (state_q != ARB_IDLE) & stb_o;
      wd_clr = (state_q == ARB_IDLE) | term | rst_i;
      fire   = wd_tc & ~term;
      tmo_o  = fire;
   end

   // Terminations go only to the owner.
   always_comb begin
      m0_ack_o = (state_q == ARB_GNT0) & ack_i;
      m0_err_o = (state_q == ARB_GNT0) & (err_i | fire);
      m1_ack_o = (state_q == ARB_GNT1) & ack_i;
      m1_err_o = (state_q == ARB_GNT1) & (err_i | fire);
   end

   // Next-state: grant from IDLE, release on cyc drop or watchdog abort.
   always_comb begin
      state_d = state_q;
      blk0_d  = blk0_q & m0_cyc_i;
      blk1_d  = blk1_q & m1_cyc_i;
`ifdef VGA_ARB_RR_EN
      last1_d = last1_q;
`endif
      req0 = m0_cyc_i & ~blk0_q;
      req1 = m1_cyc_i & ~blk1_q;
      case (state_q)
         ARB_IDLE: begin
            if (req0 && req1) begin
`ifdef VGA_ARB_RR_EN
               state_d = last1_q ? ARB_GNT0 : ARB_GNT1;
`else
               state_d = ARB_GNT0;
`endif
            end else if (req0) begin
               state_d = ARB_GNT0;
            end else if (req1) begin
               state_d = ARB_GNT1;
            end
`ifdef VGA_ARB_RR_EN
            if (state_d != ARB_IDLE) begin
               last1_d = (state_d == ARB_GNT1);
            end
`endif
         end
         ARB_GNT0: begin
            if (!m0_cyc_i) begin
               state_d = ARB_IDLE;
            end else if (fire) begin
               state_d = ARB_IDLE;
               blk0_d  = 1'b1;
            end
         end
         ARB_GNT1: begin
            if (!m1_cyc_i) begin
               state_d = ARB_IDLE;
            end else if (fire) begin
               state_d = ARB_IDLE;
               blk1_d  = 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // Synchronous reset has the same effect as nrst_i, taken at the edge.
      if (rst_i) begin
         state_d = ARB_IDLE;
         blk0_d  = 1'b0;
         blk1_d  = 1'b0;
`ifdef VGA_ARB_RR_EN
         last1_d = 1'b1;
`endif
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= ARB_IDLE;
         blk0_q  <= 1'b0;
         blk1_q  <= 1'b0;
`ifdef VGA_ARB_RR_EN
         last1_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         blk0_q  <= blk0_d;
         blk1_q  <= blk1_d;
`ifdef VGA_ARB_RR_EN
         last1_q <= last1_d;
`endif
      end
   end

   vga_arb_wdog #(
      .TO_W (TO_W)
   ) u_wdog (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .clr_i  (wd_clr),
      .en_i   (wd_en),
      .tc_o   (wd_tc)
   );

endmodule

// File: tb/tb_vga_wb_arbiter.sv
// Scoreboard bench for vga_wb_arbiter: each stimulus cycle pushes its hand-computed
// expected bus view; a negedge monitor pops and compares.
module tb_vga_wb_arbiter;

   localparam int unsigned TO_W = 4;
   localparam logic [31:0] M0_ADR = 32'hA000_0010;
   localparam logic [3:0]  M0_SEL = 4'b0011;
   localparam logic [31:0] M1_ADR = 32'hB000_0020;
   localparam logic [3:0]  M1_SEL = 4'b1100;

   logic        clk_i = 1'b0;
   logic        nrst_i, rst_i;
   logic        m0_cyc_i, m0_stb_i, m0_cab_i, m0_we_i;
   logic [31:0] m0_adr_i;
   logic [3:0]  m0_sel_i;
   logic        m0_ack_o, m0_err_o;
   logic        m1_cyc_i, m1_stb_i, m1_cab_i, m1_we_i;
   logic [31:0] m1_adr_i;
   logic [3:0]  m1_sel_i;
   logic        m1_ack_o, m1_err_o;
   logic        cyc_o, stb_o, cab_o, we_o;
   logic [31:0] adr_o;
   logic [3:0]  sel_o;
   logic        ack_i, err_i;
   logic [31:0] dat_i;
   logic [1:0]  gnt_o;
   logic        tmo_o;

   always #5 clk_i = ~clk_i;

   vga_wb_arbiter #(
      .TO_W (TO_W)
   ) dut (
      .clk_i    (clk_i),
      .nrst_i   (nrst_i),
      .rst_i    (rst_i),
      .m0_cyc_i (m0_cyc_i),
      .m0_stb_i (m0_stb_i),
      .m0_cab_i (m0_cab_i),
      .m0_we_i  (m0_we_i),
      .m0_adr_i (m0_adr_i),
      .m0_sel_i (m0_sel_i),
      .m0_ack_o (m0_ack_o),
      .m0_err_o (m0_err_o),
      .m1_cyc_i (m1_cyc_i),
      .m1_stb_i (m1_stb_i),
      .m1_cab_i (m1_cab_i),
      .m1_we_i  (m1_we_i),
      .m1_adr_i (m1_adr_i),
      .m1_sel_i (m1_sel_i),
      .m1_ack_o (m1_ack_o),
      .m1_err_o (m1_err_o),
      .cyc_o    (cyc_o),
      .stb_o    (stb_o),
      .cab_o    (cab_o),
      .we_o     (we_o),
      .adr_o    (adr_o),
      .sel_o    (sel_o),
      .ack_i    (ack_i),
      .err_i    (err_i),
      .dat_i    (dat_i),
      .gnt_o    (gnt_o),
      .tmo_o    (tmo_o)
   );

   typedef struct packed {
      logic [1:0]  gnt;
      logic        cyc;
      logic        stb;
      logic        cab;
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        a0;
      logic        a1;
      logic        e0;
      logic        e1;
      logic        tmo;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    tests_run    = 0;
   int    tests_failed = 0;

   function automatic obs_t sample();
      obs_t o;
      o.gnt = gnt_o; o.cyc = cyc_o; o.stb = stb_o; o.cab = cab_o; o.we = we_o;
      o.adr = adr_o; o.sel = sel_o;
      o.a0 = m0_ack_o; o.a1 = m1_ack_o; o.e0 = m0_err_o; o.e1 = m1_err_o; o.tmo = tmo_o;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("gnt=%b cyc=%b stb=%b cab=%b we=%b adr=%h sel=%b ack=%b%b err=%b%b tmo=%b",
                       o.gnt, o.cyc, o.stb, o.cab, o.we, o.adr, o.sel,
                       o.a1, o.a0, o.e1, o.e0, o.tmo);
   endfunction

   // Monitor: compare the DUT's bus view against the next expected cycle.
   always @(negedge clk_i) begin
      obs_t  e;
      obs_t  a;
      string n;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = sample();
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL %s: got %s, expected %s", n, fmt(a), fmt(e));
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus plus its expected response; called at posedge+1.
   task automatic step(input string nm, input bit c0, input bit s0, input bit c1,
                       input bit s1, input bit ack, input bit err, input logic [1:0] g,
                       input bit a0, input bit a1, input bit e0, input bit e1, input bit tmo);
      obs_t e;
      m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1;
      ack_i = ack; err_i = err;
      e = '0;
      e.gnt = g;
      e.sel = 4'b1111;
      if (g == 2'b01) begin
         e.cyc = c0; e.stb = s0; e.cab = 1'b1; e.we = 1'b0; e.adr = M0_ADR; e.sel = M0_SEL;
      end else if (g == 2'b10) begin
         e.cyc = c1; e.stb = s1; e.cab = 1'b0; e.we = 1'b1; e.adr = M1_ADR; e.sel = M1_SEL;
      end
      e.a0 = a0; e.a1 = a1; e.e0 = e0; e.e1 = e1; e.tmo = tmo;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      nrst_i = 1'b0; rst_i = 1'b0;
      m0_cyc_i = 0; m0_stb_i = 0; m0_cab_i = 1'b1; m0_we_i = 1'b0;
      m0_adr_i = M0_ADR; m0_sel_i = M0_SEL;
      m1_cyc_i = 0; m1_stb_i = 0; m1_cab_i = 1'b0; m1_we_i = 1'b1;
      m1_adr_i = M1_ADR; m1_sel_i = M1_SEL;
      ack_i = 0; err_i = 0; dat_i = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_gnt", {30'd0, gnt_o}, 32'd0);
      check("reset_term", {27'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, tmo_o}, 32'd0);
      check("reset_sel", {28'd0, sel_o}, 32'hF);
      nrst_i = 1'b1;
      step("idle_after_reset", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

      // m0 alone: 4-beat burst with ack every cycle.
      step("m0_req", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      for (int k = 1; k <= 4; k++)
         step($sformatf("m0_beat%0d", k), 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      step("m0_drop", 0,0,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("m0_idle", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

`ifndef VGA_ARB_RR_EN
      // Fixed priority tie, then handover through one idle cycle with an error beat.
      step("fp_both_req", 1,1,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("fp_m0_wins", 1,1,1,1,1,0, 2'b01, 1,0,0,0,0);
      step("fp_m0_drop", 0,0,1,1,0,0, 2'b01, 0,0,0,0,0);
      step("fp_gap", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("fp_m1_ack", 0,0,1,1,1,0, 2'b10, 0,1,0,0,0);
      step("fp_m1_err", 0,0,1,1,0,1, 2'b10, 0,0,0,1,0);
      step("fp_m1_drop", 0,0,0,0,0,0, 2'b10, 0,0,0,0,0);
      step("fp_idle", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);
`endif

      // Synchronous reset mid-burst, then regrant.
      step("srst_req", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      step("srst_beat", 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      rst_i = 1'b1;
      step("srst_edge", 1,1,0,0,0,0, 2'b01, 0,0,0,0,0);
      rst_i = 1'b0;
      step("srst_idle", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      step("srst_regrant", 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      step("srst_drop", 0,0,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("srst_end", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

`ifdef VGA_ARB_RR_EN
      // Round-robin: alternating grants m0, m1, m0 with one idle cycle between.
      rst_i = 1'b1;
      step("rr_rst", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);
      rst_i = 1'b0;
      step("rr_tie0", 1,1,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("rr_m0_b1", 1,1,1,1,1,0, 2'b01, 1,0,0,0,0);
      step("rr_m0_b2", 1,1,1,1,1,0, 2'b01, 1,0,0,0,0);
      step("rr_m0_drop", 0,0,1,1,0,0, 2'b01, 0,0,0,0,0);
      step("rr_tie1", 1,1,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("rr_m1_b1", 1,1,1,1,1,0, 2'b10, 0,1,0,0,0);
      step("rr_m1_b2", 1,1,1,1,1,0, 2'b10, 0,1,0,0,0);
      step("rr_m1_drop", 1,1,0,0,0,0, 2'b10, 0,0,0,0,0);
      step("rr_tie2", 1,1,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("rr_m0_again", 1,1,1,1,1,0, 2'b01, 1,0,0,0,0);
      step("rr_m0_drop2", 0,0,1,1,0,0, 2'b01, 0,0,0,0,0);
      step("rr_gap", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("rr_m1_drop2", 0,0,0,0,0,0, 2'b10, 0,0,0,0,0);
      step("rr_idle", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);
`endif

      // Watchdog: m1 hangs, fires on the 15th strobe cycle, stays blocked until cyc low.
      step("wd_m1_req", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      for (int k = 1; k <= 15; k++) begin
         if (k == 15)
            step("wd_fire", 1,1,1,1,0,0, 2'b10, 0,0,0,1,1);
         else
            step($sformatf("wd_wait%0d", k), (k >= 10), (k >= 10), 1,1,0,0, 2'b10, 0,0,0,0,0);
      end
      step("wd_idle", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("wd_blocked", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("wd_m1_low", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      step("wd_m0_grant", 1,1,1,1,1,0, 2'b01, 1,0,0,0,0);
      step("wd_m0_drop", 0,0,1,1,0,0, 2'b01, 0,0,0,0,0);
      step("wd_gap", 0,0,1,1,0,0, 2'b00, 0,0,0,0,0);
      step("wd_m1_regrant", 0,0,1,1,1,0, 2'b10, 0,1,0,0,0);
      step("wd_m1_drop", 0,0,0,0,0,0, 2'b10, 0,0,0,0,0);
      step("wd_end", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

      // Ack coincides with terminal count: no error, grant held.
      step("tc_req", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      for (int k = 1; k <= 14; k++)
         step($sformatf("tc_wait%0d", k), 1,1,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("tc_ack_wins", 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      step("tc_held1", 1,1,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("tc_held2", 1,1,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("tc_drop", 0,0,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("tc_end", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

      // Asynchronous reset mid-burst.
      step("nrst_req", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      step("nrst_beat", 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      nrst_i = 1'b0;
      #1;
      check("nrst_async_bus", {29'd0, cyc_o, stb_o, 1'b0}, 32'd0);
      check("nrst_async_gnt", {30'd0, gnt_o}, 32'd0);
      step("nrst_hold1", 1,1,0,0,1,0, 2'b00, 0,0,0,0,0);
      step("nrst_hold2", 1,1,0,0,1,0, 2'b00, 0,0,0,0,0);
      nrst_i = 1'b1;
      step("nrst_release", 1,1,0,0,0,0, 2'b00, 0,0,0,0,0);
      step("nrst_regrant", 1,1,0,0,1,0, 2'b01, 1,0,0,0,0);
      step("nrst_drop", 0,0,0,0,0,0, 2'b01, 0,0,0,0,0);
      step("nrst_end", 0,0,0,0,0,0, 2'b00, 0,0,0,0,0);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_wb_arbiter.md
# vga_wb_arbiter

Two-port WISHBONE bus arbiter between the VGA frame-fetch master and a secondary master (hardware-cursor / overlay fetch), driving the single video-memory master port of the core. Grants are cycle-locked: once a master owns the bus it keeps it until it drops its cycle. A per-grant watchdog terminates hung slave accesses with a synthesized error. It sits between the VGA WISHBONE masters and the external system bus.

## Interface
- TO_W, default 8: watchdog counter width; timeout threshold is 2^TO_W−1 cycles.
- clk_i  in  1  master clock; all logic on rising edge.
- nrst_i  in  1  asynchronous active-low reset.
- rst_i  in  1  synchronous active-high reset; same effect as nrst_i, applied on the clock edge.
- m0_cyc_i, m0_stb_i, m0_cab_i, m0_we_i  in  1 each  master 0 (frame fetch) bus controls.
- m0_adr_i  in  32  master 0 address.
- m0_sel_i  in  4  master 0 byte selects.
- m0_ack_o, m0_err_o  out  1 each  master 0 termination.
- m1_cyc_i … m1_sel_i, m1_ack_o, m1_err_o: same set for master 1 (secondary).
- cyc_o, stb_o, cab_o, we_o  out  1 each  shared bus controls.
- adr_o  out  32  shared bus address.
- sel_o  out  4  shared bus byte selects.
- ack_i, err_i  in  1 each  slave termination.
- dat_i  in  32  read data, fanned out unchanged to both masters outside this block.
- gnt_o  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle.
- tmo_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE to GNT0 when m0_cyc_i is high. IDLE to GNT1 when m1_cyc_i is high and m0_cyc_i is low, except as modified in Configuration.
- GNTx to IDLE when mx_cyc_i is low. No direct GNT0↔GNT1 hop; every handover passes through IDLE for one cycle.
- Bus outputs come from a combinational mux on the registered state. In IDLE, cyc_o, stb_o, cab_o and we_o are 0, adr_o is 0, and sel_o is 4'b1111.
- ack_i and err_i are routed only to the owner. The non-owner's ack/err are always 0. In IDLE both are 0.
- Watchdog, TO_W bits:
  - Cleared on entry to GNTx and on every ack_i or err_i.
  - Increments each cycle in GNTx while stb_o is high.
  - On reaching all-ones: pulse mx_err_o and tmo_o for one cycle, then force IDLE.
  - The aborted master must drop cyc. If it has not, the arbiter does not re-grant it until its cyc has been seen low for one cycle.
- Reset (nrst_i low, or rst_i high on the edge): state IDLE, watchdog 0, gnt_o 00, tmo_o 0, all master ack/err 0.
- Reset mid-burst: outputs drop to 0 immediately (asynchronously for nrst_i). No error is issued to the interrupted master.

## Timing
- Grant latency: a request sampled high in IDLE yields cyc_o high on the next cycle.
- Owner cycle end: cyc_o falls in the same cycle as mx_cyc_i (combinational passthrough), and the state reaches IDLE at the next edge.
- Back-to-back handover (m0 drops, m1 waiting) costs exactly one idle cycle.
- ack_i and err_i reach the owner combinationally, with zero added latency.
- Watchdog fire: mx_err_o is asserted in the cycle the counter equals 2^TO_W−1, and gnt_o is 00 on the following cycle.
- Simultaneous ack_i and watchdog terminal count: ack_i wins, the counter clears, and no error is issued.

## Configuration
- VGA_ARB_RR_EN defined: round-robin. In IDLE with both requests high, grant the master not served last. A last-owner flag resets to m1, so m0 wins the first tie.
- VGA_ARB_RR_EN undefined: fixed priority; m0 always wins ties. The frame fetch must never underrun.

## Structure
- Shared package vga_arb_pkg holds:
  - the state encoding constants ARB_IDLE, ARB_GNT0, ARB_GNT1 (2 bits);
  - the one-hot grant constants.
- One sub-module, vga_arb_wdog: a loadable TO_W-bit counter with clear, enable and terminal-count output. It is instantiated once.

## Test plan
- Only m0 requests a 4-beat burst with ack every cycle → gnt_o=01 one cycle after cyc; m0_ack_o pulses 4 times; m1_ack_o stays 0.
- Both request from IDLE, fixed priority → m0 served. m0 drops cyc → 1 IDLE cycle → gnt_o=10.
- VGA_ARB_RR_EN, both keep requesting, each drops cyc after 2 beats → grants alternate m0, m1, m0, with one IDLE cycle between each.
- m1 granted, slave never acks, TO_W=4 → m1_err_o and tmo_o pulse at the 15th stb cycle; next cycle gnt_o=00; m0 then granted.
- Ack arrives in the same cycle as terminal count → no err, no tmo_o, grant held.
- nrst_i pulsed low mid-burst of m0 → cyc_o, stb_o and gnt_o go 0 at once. After release with m0_cyc_i high → regrant one cycle later.
